jk_excite_seq: RTL and testbench

Excitation sequencer that drives a bank of negedge-triggered JK flip-flops. It takes target register values through a valid/ready queue and computes per-bit J/K excitation from the bank's fed-back Q. It then strobes the bank and checks that the bank reached the target, retrying on mismatch. It is the write side of the team's JK register bank: the bank turns J/K into Q, and this block turns desired Q into J/K.

---
 rtl/jk_excite_seq.sv | 176 +++++++++++++++++
 tb/tb_jk_excite_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_seq.sv
// Write-side sequencer for a negedge JK register bank: queues target words,
// derives per-bit J/K from the fed-back Q, strobes the bank and re-drives on mismatch.
module jk_excite_seq #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int MAX_RETRY  = 2,
    parameter int USE_TOGGLE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             jk_en,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits,
    input  logic             err_clear,
    output logic [1:0]       dbg_state
);

    // Handshake: a word is accepted on any posedge where tgt_valid && tgt_ready;
    // tgt_ready depends only on queue occupancy, never on tgt_valid.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRIVE = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tgt_reg_q, tgt_reg_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             jk_en_q, jk_en_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic             push, pop, fail, match;
    logic [WIDTH-1:0] diff;

    assign tgt_ready = (count_q != CW'(DEPTH));
    assign push      = tgt_valid && tgt_ready;
    assign match     = (q_fb == tgt_reg_q);
    assign diff      = q_fb ^ tgt_reg_q;

    always_comb begin
        state_d    = state_q;
        tgt_reg_d  = tgt_reg_q;
        retry_d    = retry_q;
        j_d        = '0;
        k_d        = '0;
        jk_en_d    = 1'b0;
        err_d      = err_q;
        err_bits_d = err_bits_q;
        pop        = 1'b0;
        fail       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    tgt_reg_d = mem_q[rd_ptr_q];
                    retry_d   = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                // Excitation lands in j_q/k_q so it is presented for the whole DRIVE cycle.
                jk_en_d = 1'b1;
                if (USE_TOGGLE != 0) begin
                    j_d = diff;
                    k_d = diff;
                end else begin
                    j_d = tgt_reg_q & ~q_fb;
                    k_d = q_fb & ~tgt_reg_q;
                end
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (match) begin
                    state_d = S_IDLE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_LOAD;
                end else begin
                    fail    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh failure outranks a simultaneous clear.
        if (fail) begin
            err_d      = 1'b1;
            err_bits_d = diff;
        end else if (err_clear) begin
            err_d      = 1'b0;
            err_bits_d = '0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = tgt_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tgt_reg_q  <= '0;
            retry_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            jk_en_q    <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tgt_reg_q  <= tgt_reg_d;
            retry_q    <= retry_d;
            j_q        <= j_d;
            k_q        <= k_d;
            jk_en_q    <= jk_en_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
            mem_q      <= mem_d;
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign jk_en     = jk_en_q;
    assign done      = (state_q == S_CHECK) && match;
    assign err       = err_q;
    assign err_bits  = err_bits_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: negedge JK bank model with fault injection, a
// transaction-level reference model checked every cycle, and directed literal checks.
module tb_jk_excite_seq;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int MAX_RETRY = 2;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic         tgt_ready;
  logic [W-1:0] q_fb;
  logic [W-1:0] J, K, err_bits;
  logic         jk_en, done, err;
  logic         err_clear = 1'b0;
  logic [1:0]   dbg_state;

  logic         t_valid = 1'b0;
  logic [W-1:0] t_data = '0;
  logic         t_ready, t_jk_en, t_done, t_err;
  logic [W-1:0] t_j, t_k, t_err_bits, t_fb;
  logic [1:0]   t_dbg;

  jk_excite_seq #(.WIDTH(W), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .USE_TOGGLE(0)) dut (
    .clock(clock), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(tgt_ready), .q_fb(q_fb), .J(J), .K(K), .jk_en(jk_en), .done(done),
    .err(err), .err_bits(err_bits), .err_clear(err_clear), .dbg_state(dbg_state));

  jk_excite_seq #(.WIDTH(W), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .USE_TOGGLE(1)) u_tog (
    .clock(clock), .reset_n(reset_n), .tgt_valid(t_valid), .tgt_data(t_data),
    .tgt_ready(t_ready), .q_fb(t_fb), .J(t_j), .K(t_k), .jk_en(t_jk_en), .done(t_done),
    .err(t_err), .err_bits(t_err_bits), .err_clear(1'b0), .dbg_state(t_dbg));

  // external JK banks (negedge), with stuck-at-0 mask and "ignore next drive" faults
  logic [W-1:0] bank_q = '0;
  logic [W-1:0] t_bank_q = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] preset_val = '0;
  logic         preset_req = 1'b0;
  int           ign_req = 0;
  int           ign_done = 0;
  assign q_fb = bank_q;
  assign t_fb = t_bank_q;

  function automatic logic [W-1:0] jk_step(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  always @(negedge clock) begin
    if (preset_req) begin
      bank_q   <= preset_val;
      t_bank_q <= preset_val;
    end else begin
      if (jk_en && (ign_req != ign_done)) ign_done <= ign_done + 1;
      else bank_q <= jk_step(bank_q, J, K) & ~stuck0;
      t_bank_q <= jk_step(t_bank_q, t_j, t_k);
    end
  end

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic         m_busy = 1'b0;
  int           m_phase = 0;
  int           m_tries = 0;
  logic [W-1:0] m_tgt = '0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_err_bits = '0;
  logic [W-1:0] m_j = '0, m_k = '0;
  int           drv_t[$];
  int           done_t[$];
  logic [W-1:0] done_val[$];
  logic [W-1:0] last_j = '0, last_k = '0, t_last_j = '0, t_last_k = '0;
  int           nr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // reference model + per-cycle compare
  initial begin
    logic         push, fb_match;
    logic [W-1:0] exp_j, exp_k;
    forever begin
      @(posedge clock);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        m_busy = 1'b0;
        m_err = 1'b0;
        m_err_bits = '0;
      end else begin
        push = tgt_valid && (exp_q.size() < DEPTH);
        if (!m_busy) begin
          if (exp_q.size() > 0) begin
            m_tgt = exp_q.pop_front();
            m_busy = 1'b1;
            m_phase = 0;
            m_tries = 0;
          end
          if (err_clear) begin
            m_err = 1'b0;
            m_err_bits = '0;
          end
        end else if (m_phase == 0) begin
          m_j = m_tgt & ~bank_q;
          m_k = bank_q & ~m_tgt;
          m_phase = 1;
          if (err_clear) begin m_err = 1'b0; m_err_bits = '0; end
        end else if (m_phase == 1) begin
          m_phase = 2;
          if (err_clear) begin m_err = 1'b0; m_err_bits = '0; end
        end else begin
          if (bank_q == m_tgt) begin
            m_busy = 1'b0;
            if (err_clear) begin m_err = 1'b0; m_err_bits = '0; end
          end else if (m_tries < MAX_RETRY) begin
            m_tries++;
            m_phase = 0;
            if (err_clear) begin m_err = 1'b0; m_err_bits = '0; end
          end else begin
            m_err = 1'b1;
            m_err_bits = bank_q ^ m_tgt;
            m_busy = 1'b0;
          end
        end
        if (push) exp_q.push_back(tgt_data);
      end
      #1;
      if (reset_n) begin
        exp_j = (m_busy && m_phase == 1) ? m_j : '0;
        exp_k = (m_busy && m_phase == 1) ? m_k : '0;
        fb_match = m_busy && (m_phase == 2) && (bank_q == m_tgt);
        chk("jk_en", jk_en, m_busy && m_phase == 1);
        chk("J", J, exp_j);
        chk("K", K, exp_k);
        chk("done", done, fb_match);
        chk("tgt_ready", tgt_ready, exp_q.size() < DEPTH);
        chk("err", err, m_err);
        chk("err_bits", err_bits, m_err_bits);
        if (jk_en) begin drv_t.push_back(cyc); last_j = J; last_k = K; end
        if (done) begin done_t.push_back(cyc); done_val.push_back(q_fb); end
        if (!tgt_ready) nr_cnt++;
        if (t_jk_en) begin t_last_j = t_j; t_last_k = t_k; end
      end
    end
  end

  // driver tasks
  task automatic preset(input logic [W-1:0] v);
    @(posedge clock);
    #2;
    preset_val = v;
    preset_req = 1'b1;
    @(negedge clock);
    #1;
    preset_req = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    logic r, ok;
    ok = 1'b0;
    tgt_valid = 1'b1;
    tgt_data = w;
    for (int i = 0; i < 60; i++) begin
      r = tgt_ready;
      @(posedge clock);
      #2;
      if (r) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("push_word");
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!m_busy && exp_q.size() == 0 && !tgt_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("wait_idle");
    @(negedge clock);
  endtask

  initial begin
    int bd, bn;
    logic [W-1:0] words[6];
    logic saw;
    // reset values, asynchronously asserted
    #1;
    chk("rst_J", J, 0);
    chk("rst_K", K, 0);
    chk("rst_jk_en", jk_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_bits", err_bits, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", tgt_ready, 1);

    // basic set/reset
    preset(8'h00);
    bd = drv_t.size(); bn = done_t.size();
    push_word(8'hA5);
    tgt_valid = 1'b0;
    wait_idle();
    chk("basic_drives", drv_t.size() - bd, 1);
    chk("basic_dones", done_t.size() - bn, 1);
    chk("basic_J", last_j, 8'hA5);
    chk("basic_K", last_k, 8'h00);
    chk("basic_bank", bank_q, 8'hA5);
    if (drv_t.size() > bd && done_t.size() > bn)
      chk("basic_latency", done_t[bn] - drv_t[bd], 1);

    // mixed transitions, both excitation styles
    preset(8'hF0);
    t_valid = 1'b1;
    t_data = 8'h3C;
    push_word(8'h3C);
    tgt_valid = 1'b0;
    t_valid = 1'b0;
    wait_idle();
    chk("mixed_J", last_j, 8'h0C);
    chk("mixed_K", last_k, 8'hC0);
    chk("mixed_bank", bank_q, 8'h3C);
    chk("tog_J", t_last_j, 8'hCC);
    chk("tog_K", t_last_k, 8'hCC);
    chk("tog_bank", t_bank_q, 8'h3C);

    // retry exhaustion with bit 0 stuck at 0
    preset(8'h00);
    stuck0 = 8'h01;
    bd = drv_t.size(); bn = done_t.size();
    push_word(8'h01);
    tgt_valid = 1'b0;
    wait_idle();
    chk("stuck_drives", drv_t.size() - bd, 3);
    chk("stuck_dones", done_t.size() - bn, 0);
    chk("stuck_err", err, 1);
    chk("stuck_err_bits", err_bits, 8'h01);
    stuck0 = '0;
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    chk("clear_err", err, 0);
    chk("clear_err_bits", err_bits, 0);

    // transient fault: first drive ignored
    preset(8'h00);
    ign_req++;
    bd = drv_t.size(); bn = done_t.size();
    push_word(8'h80);
    tgt_valid = 1'b0;
    wait_idle();
    chk("trans_drives", drv_t.size() - bd, 2);
    chk("trans_dones", done_t.size() - bn, 1);
    chk("trans_err", err, 0);
    chk("trans_bank", bank_q, 8'h80);
    if (drv_t.size() > bd && done_t.size() > bn)
      chk("trans_latency", done_t[bn] - drv_t[bd], 4);

    // queue full and wrap: six words held back to back
    bn = done_t.size();
    bd = nr_cnt;
    for (int i = 0; i < 6; i++) words[i] = W'($urandom);
    for (int i = 0; i < 6; i++) push_word(words[i]);
    tgt_valid = 1'b0;
    wait_idle();
    saw = (nr_cnt > bd);
    chk("burst_full_seen", saw, 1);
    chk("burst_dones", done_t.size() - bn, 6);
    if (done_t.size() - bn == 6) begin
      for (int i = 0; i < 6; i++) chk("burst_order", done_val[bn + i], words[i]);
      for (int i = 1; i < 6; i++) chk("burst_spacing", done_t[bn + i] - done_t[bn + i - 1], 4);
    end

    // randomized traffic with faults and clears
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      tgt_valid = ($urandom_range(0, 1) == 1);
      tgt_data = W'($urandom);
      err_clear = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) ign_req++;
      if ($urandom_range(0, 59) == 0) stuck0 = W'(1) << $urandom_range(0, W - 1);
      else if ($urandom_range(0, 9) == 0) stuck0 = '0;
    end
    @(negedge clock);
    tgt_valid = 1'b0;
    err_clear = 1'b0;
    stuck0 = '0;
    wait_idle();

    // reset during DRIVE with two words still queued
    preset(8'h00);
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    tgt_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (jk_en) begin saw = 1'b1; break; end
      @(posedge clock);
      #2;
    end
    if (!saw) fail_now("wait_drive");
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_J", J, 0);
    chk("mid_rst_K", K, 0);
    chk("mid_rst_jk_en", jk_en, 0);
    bd = drv_t.size(); bn = done_t.size();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", tgt_ready, 1);
    repeat (12) @(negedge clock);
    chk("post_rst_dones", done_t.size() - bn, 0);
    chk("post_rst_drives", drv_t.size() - bd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
